// File: rtl/pop_phase_sequencer.sv
// Four-phase timing sequencer: a saturating period counter is compared against the
// active phase's end time, stepping a one-hot phase output through repeated periods.

module comparator #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gteq_b
);
    assign a_gteq_b = (a >= b);
endmodule

module pop_phase_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    output logic [3:0]       phase_out,
    output logic [1:0]       phase_idx,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cycle_cnt
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [WIDTH-1:0] repeat_q, repeat_d;
    logic [WIDTH-1:0] t_q [4];
    logic [WIDTH-1:0] t_d [4];
    logic [1:0]       phase_q, phase_d;
    logic [3:0]       phase_out_q, phase_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cmp_ge;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] cycle_cnt_inc;

    comparator #(.WIDTH(WIDTH)) u_cmp (
        .a        (count_q),
        .b        (t_q[phase_q]),
        .a_gteq_b (cmp_ge)
    );

    // Saturate so the all-ones count keeps the compare true for every remaining phase.
    assign count_inc     = (count_q == '1) ? count_q : count_q + WIDTH'(1);
    assign cycle_cnt_inc = cycle_cnt_q + WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        cycle_cnt_d = cycle_cnt_q;
        repeat_d    = repeat_q;
        for (int unsigned i = 0; i < 4; i++) t_d[i] = t_q[i];
        phase_d     = phase_q;
        phase_out_d = phase_out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    if (cfg_addr[2] == 1'b0)   t_d[cfg_addr[1:0]] = cfg_data;
                    else if (cfg_addr == 3'd4) repeat_d = cfg_data;
                end
                if (start && !abort) begin
                    state_d     = ST_RUN;
                    count_d     = '0;
                    phase_d     = 2'd0;
                    cycle_cnt_d = '0;
                    busy_d      = 1'b1;
                    phase_out_d = 4'b0001;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    phase_d     = 2'd0;
                    phase_out_d = 4'b0000;
                    busy_d      = 1'b0;
                end else if (!cmp_ge) begin
                    count_d = count_inc;
                end else if (phase_q != 2'd3) begin
                    phase_d     = phase_q + 2'd1;
                    phase_out_d = phase_out_q << 1;
                    count_d     = count_inc;
                end else begin
                    cycle_cnt_d = cycle_cnt_inc;
                    if (repeat_q != '0 && cycle_cnt_inc == repeat_q) begin
                        state_d     = ST_DONE;
                        phase_d     = 2'd0;
                        phase_out_d = 4'b0000;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        count_d     = '0;
                        phase_d     = 2'd0;
                        phase_out_d = 4'b0001;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                phase_d     = 2'd0;
                phase_out_d = 4'b0000;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            cycle_cnt_q <= '0;
            repeat_q    <= WIDTH'(1);
            for (int unsigned i = 0; i < 4; i++) t_q[i] <= '0;
            phase_q     <= 2'd0;
            phase_out_q <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            cycle_cnt_q <= cycle_cnt_d;
            repeat_q    <= repeat_d;
            for (int unsigned i = 0; i < 4; i++) t_q[i] <= t_d[i];
            phase_q     <= phase_d;
            phase_out_q <= phase_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign phase_out = phase_out_q;
    assign phase_idx = phase_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_pop_phase_sequencer.sv
// Self-checking bench for pop_phase_sequencer: per-cycle phase trace checked against
// phase durations derived from effective end times of the programmed thresholds.

module tb_pop_phase_sequencer;
    localparam int W = 16;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, abort, cfg_we;
    logic [2:0]   cfg_addr;
    logic [W-1:0] cfg_data;
    logic [3:0]   phase_out;
    logic [1:0]   phase_idx;
    logic         busy, done;
    logic [W-1:0] cycle_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int m_t [4];
    int m_d [4];

    pop_phase_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .phase_out (phase_out),
        .phase_idx (phase_idx),
        .busy      (busy),
        .done      (done),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang, want completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    // Each phase ends at its effective end time: its threshold, or one past the
    // previous end when the threshold is not beyond it; capped at the counter maximum.
    function automatic void compute_durs();
        int e_prev, e;
        e = m_t[0];
        m_d[0] = e + 1;
        e_prev = e;
        for (int k = 1; k < 4; k++) begin
            if (e_prev >= MAXV) begin
                e = MAXV;
                m_d[k] = 1;
            end else begin
                e = (m_t[k] > e_prev) ? m_t[k] : e_prev + 1;
                m_d[k] = e - e_prev;
            end
            e_prev = e;
        end
    endfunction

    task automatic run_seq(input string name, input int rep, input bit cfg_t,
                           input bit cfg_rep, input bit noise);
        logic [3:0] ep;
        if (cfg_t) for (int k = 0; k < 4; k++) cfg_write(3'(k), W'(m_t[k]));
        if (cfg_rep) cfg_write(3'd4, W'(rep));
        compute_durs();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int p = 0; p < rep; p++) begin
            for (int k = 0; k < 4; k++) begin
                ep = 4'b0001 << k;
                for (int c = 0; c < m_d[k]; c++) begin
                    n_cmp++;
                    if (phase_out !== ep || phase_idx !== 2'(k) || busy !== 1'b1 ||
                        done !== 1'b0 || cycle_cnt !== W'(p)) begin
                        n_err++;
                        $display("FAIL %s_trace p=%0d k=%0d c=%0d: got out=%b idx=%0d busy=%b done=%b cnt=%0d, want out=%b idx=%0d busy=1 done=0 cnt=%0d",
                                 name, p, k, c, phase_out, phase_idx, busy, done, cycle_cnt, ep, k, p);
                    end
                    if (noise) begin
                        start    = 1'($urandom_range(0, 1));
                        cfg_we   = 1'($urandom_range(0, 1));
                        cfg_addr = 3'($urandom_range(0, 7));
                        cfg_data = W'($urandom);
                    end
                    step();
                end
            end
        end
        cfg_we = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || phase_out !== 4'b0000 || cycle_cnt !== W'(rep)) begin
            n_err++;
            $display("FAIL %s_done: got done=%b busy=%b out=%b cnt=%0d, want done=1 busy=0 out=0000 cnt=%0d",
                     name, done, busy, phase_out, cycle_cnt, rep);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || phase_out !== 4'b0000 || cycle_cnt !== W'(rep)) begin
            n_err++;
            $display("FAIL %s_after_done: got done=%b busy=%b out=%b cnt=%0d, want done=0 busy=0 out=0000 cnt=%0d",
                     name, done, busy, phase_out, cycle_cnt, rep);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: got busy=%b done=%b, want busy=0 done=0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_data = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (phase_out !== 4'b0000 || phase_idx !== 2'd0 || busy !== 1'b0 ||
            done !== 1'b0 || cycle_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_state: got out=%b idx=%0d busy=%b done=%b cnt=%0d, want all 0",
                     phase_out, phase_idx, busy, done, cycle_cnt);
        end
    endtask

    task automatic test_basic();
        m_t = '{2, 5, 6, 9};
        run_seq("basic", 1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        m_t = '{2, 5, 6, 9};
        run_seq("b2b", 3, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_nonmonotonic();
        m_t = '{4, 2, 2, 7};
        run_seq("nonmono", 2, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int rep;
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < 4; k++) m_t[k] = $urandom_range(0, 12);
            rep = $urandom_range(1, 3);
            run_seq("rand_noise", rep, 1'b1, 1'b1, 1'b1);
            // Replay without reprogramming: any write leaked through during the run shows up here.
            run_seq("rand_replay", rep, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_continuous_abort();
        logic [3:0] ep;
        m_t = '{0, 0, 0, 0};
        for (int k = 0; k < 4; k++) cfg_write(3'(k), '0);
        cfg_write(3'd4, '0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int p = 0; p < 25; p++) begin
            for (int k = 0; k < 4; k++) begin
                ep = 4'b0001 << k;
                n_cmp++;
                if (phase_out !== ep || busy !== 1'b1 || done !== 1'b0 || cycle_cnt !== W'(p)) begin
                    n_err++;
                    $display("FAIL cont_trace p=%0d k=%0d: got out=%b busy=%b done=%b cnt=%0d, want out=%b busy=1 done=0 cnt=%0d",
                             p, k, phase_out, busy, done, cycle_cnt, ep, p);
                end
                cfg_we = (p == 10 && k == 0);
                cfg_addr = 3'd0;
                cfg_data = 16'h0007;
                step();
            end
        end
        cfg_we = 1'b0;
        n_cmp++;
        if (cycle_cnt !== W'(25) || phase_out !== 4'b0001) begin
            n_err++;
            $display("FAIL cont_25: got cnt=%0d out=%b, want cnt=25 out=0001", cycle_cnt, phase_out);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (phase_out !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || cycle_cnt !== W'(25)) begin
            n_err++;
            $display("FAIL cont_abort: got out=%b busy=%b done=%b cnt=%0d, want 0000 0 0 25",
                     phase_out, busy, done, cycle_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL cont_no_done: got done=%b busy=%b, want 0 0", done, busy);
            end
        end
        run_seq("cont_cfg_kept", 1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_saturate();
        m_t = '{MAXV, MAXV, MAXV, MAXV};
        run_seq("saturate", 1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || phase_out !== 4'b0000 || done !== 1'b0) begin
            n_err++;
            $display("FAIL start_abort_idle: got busy=%b out=%b done=%b, want 0 0000 0", busy, phase_out, done);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_abort_idle_hold: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_midrun();
        for (int k = 0; k < 4; k++) cfg_write(3'(k), W'((k == 0) ? 2 : (k == 1) ? 5 : (k == 2) ? 6 : 9));
        cfg_write(3'd4, W'(2));
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        n_cmp++;
        if (phase_out !== 4'b0100) begin
            n_err++;
            $display("FAIL midrun_phase2: got out=%b, want 0100", phase_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (phase_out !== 4'b0000 || phase_idx !== 2'd0 || busy !== 1'b0 ||
            done !== 1'b0 || cycle_cnt !== '0) begin
            n_err++;
            $display("FAIL async_reset: got out=%b idx=%0d busy=%b done=%b cnt=%0d, want all 0",
                     phase_out, phase_idx, busy, done, cycle_cnt);
        end
        step();
        rst_n = 1'b1;
        step();
        // Defaults after reset: thresholds 0, repeat 1 -> a single 4-cycle period.
        m_t = '{0, 0, 0, 0};
        run_seq("post_reset_defaults", 1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_nonmonotonic();
        test_random();
        test_continuous_abort();
        test_start_abort_idle();
        test_reset_midrun();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
